// File: rtl/battle_resolver_pkg.sv
// Shared definitions for the battle resolver: FSM encoding, widths and the
// saturating-subtract helper used for damage terms.
package battle_resolver_pkg;

  localparam int BR_W    = 16;
  localparam int ROUND_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_P_HIT = 3'd2,
    S_E_HIT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [BR_W-1:0] sat_sub_f(input logic [BR_W-1:0] a,
                                                input logic [BR_W-1:0] b);
    logic [BR_W-1:0] y;
    if (a > b) begin
      y = a - b;
    end else begin
      y = {BR_W{1'b0}};
    end
    return y;
  endfunction

endpackage

// File: rtl/battle_resolver_sat_sub.sv
// sat_sub: W-bit a>b ? a-b : 0, used for both player and enemy damage.
module sat_sub
  import battle_resolver_pkg::*;
#(
  parameter int W = BR_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  // The package helper is fixed at BR_W; other widths use the same rule inline.
  if (W == BR_W) begin : g_pkg
    assign o_y = sat_sub_f(i_a, i_b);
  end else begin : g_generic
    assign o_y = (i_a > i_b) ? (i_a - i_b) : {W{1'b0}};
  end

endmodule

// File: rtl/battle_resolver.sv
// Sequential combat resolver: alternating player/enemy strikes, one per clock.
// Optional round cap enabled by the BATTLE_ROUND_LIMIT_EN macro.
module battle_resolver
  import battle_resolver_pkg::*;
#(
  parameter int W          = BR_W,
  parameter int MAX_ROUNDS = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W-1:0]       enemy_atk,
  input  logic [W-1:0]       enemy_def,
  input  logic [W-1:0]       enemy_hp,
  input  logic [W-1:0]       player_hp,
  input  logic [W-1:0]       player_atk,
  input  logic [W-1:0]       player_def,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic [W-1:0]       hp_loss,
  output logic [ROUND_W-1:0] rounds,
  output logic               timeout
);

`ifdef BATTLE_ROUND_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [W-1:0]         r_e_atk, r_e_def, r_e_hp;
  logic [W-1:0]         r_p_hp, r_p_atk, r_p_def;
  logic [W-1:0]         r_hp_loss;
  logic [ROUND_W-1:0]   r_rounds;
  logic                 r_win, r_timeout, r_done, r_busy;

  logic [W-1:0]         w_p_dmg, w_e_dmg, w_e_hp_nxt, w_loss_nxt;
  logic [W:0]           w_loss_sum;
  logic [ROUND_W-1:0]   w_rounds_nxt;
  logic                 w_cap_hit;

  sat_sub #(.W(W)) u_p_dmg (.i_a(r_p_atk), .i_b(r_e_def), .o_y(w_p_dmg));
  sat_sub #(.W(W)) u_e_dmg (.i_a(r_e_atk), .i_b(r_p_def), .o_y(w_e_dmg));

  assign w_e_hp_nxt   = (r_e_hp > w_p_dmg) ? (r_e_hp - w_p_dmg) : {W{1'b0}};
  assign w_loss_sum   = {1'b0, r_hp_loss} + {1'b0, w_e_dmg};
  assign w_loss_nxt   = w_loss_sum[W] ? {W{1'b1}} : w_loss_sum[W-1:0];
  assign w_rounds_nxt = (r_rounds == 8'hFF) ? 8'hFF : (r_rounds + 8'd1);
  assign w_cap_hit    = LIMIT_EN && (int'({24'd0, w_rounds_nxt}) >= MAX_ROUNDS);

  // Next-state decision; a lethal player hit wins over the round cap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CHECK: begin
        if (r_e_hp == {W{1'b0}}) begin
          w_next = S_DONE;
        end else if (w_p_dmg == {W{1'b0}}) begin
          w_next = S_DONE;
        end else begin
          w_next = S_P_HIT;
        end
      end
      S_P_HIT: begin
        if (w_e_hp_nxt == {W{1'b0}}) begin
          w_next = S_DONE;
        end else if (w_cap_hit) begin
          w_next = S_DONE;
        end else begin
          w_next = S_E_HIT;
        end
      end
      S_E_HIT: begin
        if (w_loss_nxt >= r_p_hp) begin
          w_next = S_DONE;
        end else begin
          w_next = S_P_HIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus done/busy, registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Operand latch and battle datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_atk   <= {W{1'b0}};
      r_e_def   <= {W{1'b0}};
      r_e_hp    <= {W{1'b0}};
      r_p_hp    <= {W{1'b0}};
      r_p_atk   <= {W{1'b0}};
      r_p_def   <= {W{1'b0}};
      r_hp_loss <= {W{1'b0}};
      r_rounds  <= 8'd0;
      r_win     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_e_atk   <= enemy_atk;
            r_e_def   <= enemy_def;
            r_e_hp    <= enemy_hp;
            r_p_hp    <= player_hp;
            r_p_atk   <= player_atk;
            r_p_def   <= player_def;
            r_hp_loss <= {W{1'b0}};
            r_rounds  <= 8'd0;
            r_win     <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        S_CHECK: begin
          if (r_e_hp == {W{1'b0}}) begin
            r_win <= 1'b1;
          end
        end
        S_P_HIT: begin
          r_e_hp   <= w_e_hp_nxt;
          r_rounds <= w_rounds_nxt;
          if (w_e_hp_nxt == {W{1'b0}}) begin
            r_win <= 1'b1;
          end else if (w_cap_hit) begin
            r_timeout <= 1'b1;
          end
        end
        S_E_HIT: begin
          r_hp_loss <= w_loss_nxt;
        end
        default: begin
          r_win <= r_win;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign win     = r_win;
  assign hp_loss = r_hp_loss;
  assign rounds  = r_rounds;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_battle_resolver.sv
// Scoreboard bench for battle_resolver: stimulus pushes expected results,
// a monitor pops and compares whenever done is presented.
module tb_battle_resolver;

`ifdef BATTLE_ROUND_LIMIT_EN
  localparam int MAXR = 3;
`else
  localparam int MAXR = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] enemy_atk = 16'd0, enemy_def = 16'd0, enemy_hp = 16'd0;
  logic [15:0] player_hp = 16'd0, player_atk = 16'd0, player_def = 16'd0;
  logic        busy, done, win, timeout;
  logic [15:0] hp_loss;
  logic [7:0]  rounds;

  typedef struct {
    logic        win;
    logic [15:0] loss;
    logic [7:0]  rounds;
    logic        tmo;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  battle_resolver #(.W(16), .MAX_ROUNDS(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .enemy_atk(enemy_atk), .enemy_def(enemy_def), .enemy_hp(enemy_hp),
    .player_hp(player_hp), .player_atk(player_atk), .player_def(player_def),
    .busy(busy), .done(done), .win(win), .hp_loss(hp_loss),
    .rounds(rounds), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic battle(input logic [15:0] php, input logic [15:0] patk, input logic [15:0] pdef,
                        input logic [15:0] ehp, input logic [15:0] edef, input logic [15:0] eatk,
                        input logic xwin, input logic [15:0] xloss, input logic [7:0] xrounds,
                        input logic xtmo, input int xlat, input bit repulse);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    player_hp = php; player_atk = patk; player_def = pdef;
    enemy_hp = ehp; enemy_def = edef; enemy_atk = eatk;
    start = 1'b1;
    e.win = xwin; e.loss = xloss; e.rounds = xrounds; e.tmo = xtmo;
    e.lat = xlat; e.scyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    // scrambled operands must not affect the running battle
    player_hp = 16'd1; player_atk = 16'd0; player_def = 16'd0;
    enemy_hp = 16'd0; enemy_def = 16'hFFFF; enemy_atk = 16'hFFFF;
    if (repulse) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    if (!done) check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && done) begin
            if (sb.size() == 0) begin
              check("unexpected_done", 32'(done), 32'd0);
            end else begin
              e = sb.pop_front();
              check("win",     32'(win),     32'(e.win));
              check("hp_loss", 32'(hp_loss), 32'(e.loss));
              check("rounds",  32'(rounds),  32'(e.rounds));
              check("timeout", 32'(timeout), 32'(e.tmo));
              check("latency", 32'(cyc - e.scyc), 32'(e.lat));
              check("busy_at_done", 32'(busy), 32'd1);
            end
          end
        end
      end
      begin : stimulus
        #12;
        check("reset_outputs", 32'({done, busy, win, timeout, hp_loss, rounds}), 32'd0);
        #10 rst_n = 1'b1;
        // php patk pdef ehp edef eatk | win loss rounds tmo lat repulse
        battle(16'd100, 16'd10, 16'd0, 16'd30, 16'd2, 16'd1, 1'b1, 16'd3, 8'd4, 1'b0, 9, 1'b0);
        battle(16'd50, 16'd2, 16'd0, 16'd10, 16'd5, 16'd3, 1'b0, 16'd0, 8'd0, 1'b0, 2, 1'b0);
        battle(16'd5, 16'd3, 16'd0, 16'd100, 16'd0, 16'd10, 1'b0, 16'd10, 8'd1, 1'b0, 4, 1'b0);
        battle(16'd10, 16'd5, 16'd6, 16'd20, 16'd0, 16'd4, 1'b1, 16'd0, 8'd4, 1'b0, 9, 1'b0);
        battle(16'd10, 16'd5, 16'd0, 16'd0, 16'd0, 16'd4, 1'b1, 16'd0, 8'd0, 1'b0, 2, 1'b0);
        battle(16'hFFFF, 16'd1, 16'd0, 16'd100, 16'd0, 16'h8000, 1'b0, 16'hFFFF, 8'd2, 1'b0, 6, 1'b0);
        battle(16'd10, 16'd50, 16'd0, 16'd7, 16'd0, 16'd9, 1'b1, 16'd0, 8'd1, 1'b0, 3, 1'b0);
        battle(16'd100, 16'd10, 16'd0, 16'd30, 16'd2, 16'd1, 1'b1, 16'd3, 8'd4, 1'b0, 9, 1'b1);
`ifdef BATTLE_ROUND_LIMIT_EN
        battle(16'd100, 16'd1, 16'd0, 16'd10, 16'd0, 16'd0, 1'b0, 16'd0, 8'd3, 1'b1, 7, 1'b0);
        battle(16'd100, 16'd1, 16'd0, 16'd3, 16'd0, 16'd0, 1'b1, 16'd0, 8'd3, 1'b0, 7, 1'b0);
`endif
        // reset asserted at cycle 3 of a battle: no done, all outputs cleared
        @(posedge clk); #1;
        player_hp = 16'd100; player_atk = 16'd10; player_def = 16'd0;
        enemy_hp = 16'd30; enemy_def = 16'd2; enemy_atk = 16'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({done, busy, win, timeout, hp_loss, rounds}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        check("abort_idle", 32'({done, busy}), 32'd0);
        battle(16'd5, 16'd3, 16'd0, 16'd100, 16'd0, 16'd10, 1'b0, 16'd10, 8'd1, 1'b0, 4, 1'b0);
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
